light_dir_seq: RTL and testbench

LIGHT_DIR_SEQ -- requirements
Module: light_dir_seq

---
 rtl/light_dir_seq.sv | 149 ++++++++++++++
 tb/tb_light_dir_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_dir_seq.sv
// Light direction sequencer: holds NUM_LIGHTS light positions and, for each accepted
// surface point, streams light-minus-surface vectors with their squared length.
module light_dir_seq #(
    parameter int WIDTH      = 16,
    parameter int NUM_LIGHTS = 4,
    parameter int SAT_EN     = 1,
    localparam int IW        = $clog2(NUM_LIGHTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    light_we,
    input  logic [IW-1:0]           light_idx,
    input  logic signed [WIDTH-1:0] light_x,
    input  logic signed [WIDTH-1:0] light_y,
    input  logic signed [WIDTH-1:0] light_z,
    input  logic                    surf_valid,
    output logic                    surf_ready,
    input  logic signed [WIDTH-1:0] surface_x,
    input  logic signed [WIDTH-1:0] surface_y,
    input  logic signed [WIDTH-1:0] surface_z,
    output logic                    dir_valid,
    input  logic                    dir_ready,
    output logic signed [WIDTH-1:0] dir_x,
    output logic signed [WIDTH-1:0] dir_y,
    output logic signed [WIDTH-1:0] dir_z,
    output logic [2*WIDTH-1:0]      dir_len2,
    output logic [IW-1:0]           dir_idx,
    output logic                    dir_last,
    output logic                    dir_sat
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] tab_x [NUM_LIGHTS];
    logic signed [WIDTH-1:0] tab_y [NUM_LIGHTS];
    logic signed [WIDTH-1:0] tab_z [NUM_LIGHTS];
    logic signed [WIDTH-1:0] cap_x, cap_y, cap_z;
    logic [IW-1:0]           cnt;

    function automatic logic ovf(input logic signed [WIDTH:0] d);
        return d[WIDTH] != d[WIDTH-1];
    endfunction

    function automatic logic signed [WIDTH-1:0] fit(input logic signed [WIDTH:0] d);
        if (SAT_EN != 0 && ovf(d))
            return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return d[WIDTH-1:0];
    endfunction

    function automatic logic [2*WIDTH-1:0] sq(input logic signed [WIDTH-1:0] v);
        logic signed [2*WIDTH-1:0] w;
        w = (2*WIDTH)'(v);
        return w * w;
    endfunction

    // Stage p0: table read and subtraction, feeding the output register directly
    logic                    issue_p0;
    logic signed [WIDTH:0]   diff_x_p0, diff_y_p0, diff_z_p0;
    logic signed [WIDTH-1:0] fit_x_p0, fit_y_p0, fit_z_p0;
    logic                    ovf_p0;
    logic [2*WIDTH-1:0]      len2_p0;

    assign issue_p0  = (state == RUN) && (!dir_valid || dir_ready);
    assign diff_x_p0 = (WIDTH+1)'(tab_x[cnt]) - (WIDTH+1)'(cap_x);
    assign diff_y_p0 = (WIDTH+1)'(tab_y[cnt]) - (WIDTH+1)'(cap_y);
    assign diff_z_p0 = (WIDTH+1)'(tab_z[cnt]) - (WIDTH+1)'(cap_z);
    assign fit_x_p0  = fit(diff_x_p0);
    assign fit_y_p0  = fit(diff_y_p0);
    assign fit_z_p0  = fit(diff_z_p0);
    assign ovf_p0    = ovf(diff_x_p0) | ovf(diff_y_p0) | ovf(diff_z_p0);
    assign len2_p0   = sq(fit_x_p0) + sq(fit_y_p0) + sq(fit_z_p0);

    // Light table: written whenever light_we is high, independent of the sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
                tab_z[i] <= '0;
            end
        end else if (light_we) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                if (light_idx == IW'(i)) begin
                    tab_x[i] <= light_x;
                    tab_y[i] <= light_y;
                    tab_z[i] <= light_z;
                end
            end
        end
    end

    // Stage p1: sequencer state and registered direction outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            surf_ready <= 1'b1;
            cap_x      <= '0;
            cap_y      <= '0;
            cap_z      <= '0;
            cnt        <= '0;
            dir_valid  <= 1'b0;
            dir_x      <= '0;
            dir_y      <= '0;
            dir_z      <= '0;
            dir_len2   <= '0;
            dir_idx    <= '0;
            dir_last   <= 1'b0;
            dir_sat    <= 1'b0;
        end else begin
            if (dir_ready)
                dir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (surf_valid && surf_ready) begin
                        cap_x      <= surface_x;
                        cap_y      <= surface_y;
                        cap_z      <= surface_z;
                        cnt        <= '0;
                        state      <= RUN;
                        surf_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (issue_p0) begin
                        dir_valid <= 1'b1;
                        dir_x     <= fit_x_p0;
                        dir_y     <= fit_y_p0;
                        dir_z     <= fit_z_p0;
                        dir_len2  <= len2_p0;
                        dir_sat   <= ovf_p0;
                        dir_idx   <= cnt;
                        dir_last  <= (cnt == IW'(NUM_LIGHTS-1));
                        cnt       <= cnt + IW'(1);
                        if (cnt == IW'(NUM_LIGHTS-1)) begin
                            state      <= IDLE;
                            surf_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    surf_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_dir_seq.sv
// Randomized bench for light_dir_seq: a saturating and a wrapping instance share stimulus
// and are compared against an arithmetic model of the light table and vector maths.
module tb_light_dir_seq;

    localparam int NL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic light_we = 1'b0;
    logic [1:0] light_idx = '0;
    logic signed [15:0] light_x = '0, light_y = '0, light_z = '0;
    logic surf_valid = 1'b0;
    logic signed [15:0] surface_x = '0, surface_y = '0, surface_z = '0;
    logic dir_ready = 1'b0;

    logic surf_ready, dir_valid, dir_last, dir_sat;
    logic signed [15:0] dir_x, dir_y, dir_z;
    logic [31:0] dir_len2;
    logic [1:0] dir_idx;
    logic surf_ready_w, dir_valid_w, dir_last_w, dir_sat_w;
    logic signed [15:0] dir_x_w, dir_y_w, dir_z_w;
    logic [31:0] dir_len2_w;
    logic [1:0] dir_idx_w;

    always #5 clk = ~clk;

    light_dir_seq #(.WIDTH(16), .NUM_LIGHTS(NL), .SAT_EN(1)) dut (
        .clk(clk), .reset(reset), .light_we(light_we), .light_idx(light_idx),
        .light_x(light_x), .light_y(light_y), .light_z(light_z),
        .surf_valid(surf_valid), .surf_ready(surf_ready),
        .surface_x(surface_x), .surface_y(surface_y), .surface_z(surface_z),
        .dir_valid(dir_valid), .dir_ready(dir_ready),
        .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z), .dir_len2(dir_len2),
        .dir_idx(dir_idx), .dir_last(dir_last), .dir_sat(dir_sat));

    light_dir_seq #(.WIDTH(16), .NUM_LIGHTS(NL), .SAT_EN(0)) dut_w (
        .clk(clk), .reset(reset), .light_we(light_we), .light_idx(light_idx),
        .light_x(light_x), .light_y(light_y), .light_z(light_z),
        .surf_valid(surf_valid), .surf_ready(surf_ready_w),
        .surface_x(surface_x), .surface_y(surface_y), .surface_z(surface_z),
        .dir_valid(dir_valid_w), .dir_ready(dir_ready),
        .dir_x(dir_x_w), .dir_y(dir_y_w), .dir_z(dir_z_w), .dir_len2(dir_len2_w),
        .dir_idx(dir_idx_w), .dir_last(dir_last_w), .dir_sat(dir_sat_w));

    int checks = 0;
    int errors = 0;
    int mx[NL], my[NL], mz[NL];
    int csx, csy, csz;
    int e_x[2], e_y[2], e_z[2];
    bit e_sat[2];
    longint e_len[2];
    int got_x[NL], got_y[NL], got_z[NL], got_xw[NL];
    longint got_len[NL];
    bit got_sat[NL], got_satw[NL];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact difference, then clamp (m=1) or wrap into 16 bits (m=0)
    function automatic void fitm(input int full, input int m, output int d, output bit ov);
        ov = (full > 32767) || (full < -32768);
        if (!ov) d = full;
        else if (m == 1) d = (full > 0) ? 32767 : -32768;
        else d = (full > 0) ? full - 65536 : full + 65536;
    endfunction

    function automatic void expect_for(input int i);
        bit ox, oy, oz;
        for (int m = 0; m < 2; m++) begin
            fitm(mx[i] - csx, m, e_x[m], ox);
            fitm(my[i] - csy, m, e_y[m], oy);
            fitm(mz[i] - csz, m, e_z[m], oz);
            e_sat[m] = ox | oy | oz;
            e_len[m] = longint'(e_x[m]) * e_x[m] + longint'(e_y[m]) * e_y[m]
                     + longint'(e_z[m]) * e_z[m];
        end
    endfunction

    task automatic cmp_result(input int k);
        expect_for(k);
        check("valid", dir_valid, 1);
        check("idx", dir_idx, k);
        check("last", dir_last, (k == NL-1));
        check("x", dir_x, e_x[1]);
        check("y", dir_y, e_y[1]);
        check("z", dir_z, e_z[1]);
        check("len2", dir_len2, e_len[1]);
        check("sat", dir_sat, e_sat[1]);
        check("w_valid", dir_valid_w, 1);
        check("w_idx", dir_idx_w, k);
        check("w_last", dir_last_w, (k == NL-1));
        check("w_x", dir_x_w, e_x[0]);
        check("w_y", dir_y_w, e_y[0]);
        check("w_z", dir_z_w, e_z[0]);
        check("w_len2", dir_len2_w, e_len[0]);
        check("w_sat", dir_sat_w, e_sat[0]);
    endtask

    task automatic wr(input int i, input int x, input int y, input int z);
        light_we = 1'b1;
        light_idx = 2'(i);
        light_x = 16'(x); light_y = 16'(y); light_z = 16'(z);
        step();
        light_we = 1'b0;
        mx[i] = x; my[i] = y; mz[i] = z;
    endtask

    task automatic accept(input int sx, input int sy, input int sz);
        int cyc = 0;
        while (!surf_ready && cyc < 50) begin
            step();
            cyc++;
        end
        check("accept_wait", surf_ready, 1);
        surface_x = 16'(sx); surface_y = 16'(sy); surface_z = 16'(sz);
        csx = sx; csy = sy; csz = sz;
        surf_valid = 1'b1;
        step();
        surf_valid = 1'b0;
        check("busy", surf_ready, 0);
        check("w_busy", surf_ready_w, 0);
    endtask

    task automatic run_point(input int sx, input int sy, input int sz, input int stall);
        int k = 0;
        int cyc = 0;
        bit held;
        logic signed [15:0] hx;
        logic [31:0] hlen;
        logic [1:0] hidx;
        accept(sx, sy, sz);
        while (k < NL && cyc < 200) begin
            dir_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall);
            surface_x = 16'($urandom); surface_y = 16'($urandom); surface_z = 16'($urandom);
            if (dir_valid && dir_ready) begin
                cmp_result(k);
                if (stall == 0) check("latency", cyc, k + 1);
                if (k == NL-1) check("ready_after_last", surf_ready, 1);
                got_x[k] = dir_x; got_y[k] = dir_y; got_z[k] = dir_z;
                got_len[k] = dir_len2; got_sat[k] = dir_sat;
                got_xw[k] = dir_x_w; got_satw[k] = dir_sat_w;
                k++;
            end
            held = dir_valid && !dir_ready;
            hx = dir_x; hlen = dir_len2; hidx = dir_idx;
            step();
            cyc++;
            if (held) begin
                check("hold_valid", dir_valid, 1);
                check("hold_idx", dir_idx, hidx);
                check("hold_x", dir_x, hx);
                check("hold_len2", dir_len2, hlen);
            end
        end
        if (k < NL) check("results_timeout", k, NL);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            mx[i] = 0; my[i] = 0; mz[i] = 0;
        end
    endtask

    initial begin
        logic signed [15:0] sx;
        logic [31:0] slen;
        clear_model();
        #2 reset = 1'b0;
        #20;
        check("rst_surf_ready", surf_ready, 1);
        check("rst_dir_valid", dir_valid, 0);
        check("rst_dir_x", dir_x, 0);
        check("rst_len2", dir_len2, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        check("post_rst_surf_ready", surf_ready, 1);
        check("post_rst_dir_valid", dir_valid, 0);
        check("post_rst_dir_z", dir_z, 0);
        check("post_rst_dir_idx", dir_idx, 0);

        // Basic sequence with fixed light 0
        wr(0, 100, 50, -20);
        run_point(10, 20, 30, 0);
        check("basic_x", got_x[0], 90);
        check("basic_y", got_y[0], 30);
        check("basic_z", got_z[0], -50);
        check("basic_len2", got_len[0], 11500);
        check("basic_sat", got_sat[0], 0);

        // Out-of-range component: clamp vs wrap
        wr(1, 32767, 5, -5);
        run_point(-100, 0, 0, 0);
        check("clamp_x", got_x[1], 32767);
        check("clamp_sat", got_sat[1], 1);
        check("wrap_x", got_xw[1], -32669);
        check("wrap_sat", got_satw[1], 1);

        // Stall at idx 1 for three cycles
        dir_ready = 1'b1;
        accept(7, -8, 9);
        step();
        step();
        cmp_result(1);
        dir_ready = 1'b0;
        sx = dir_x; slen = dir_len2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_idx", dir_idx, 1);
            check("stall_valid", dir_valid, 1);
            check("stall_x", dir_x, sx);
            check("stall_len2", dir_len2, slen);
        end
        dir_ready = 1'b1;
        step();
        cmp_result(2);
        step();
        cmp_result(3);
        step();
        check("drain_valid", dir_valid, 0);

        // Table write at the same edge as the issue of idx 2
        wr(2, 1000, -2000, 300);
        dir_ready = 1'b1;
        accept(5, 6, 7);
        step();
        step();
        light_we = 1'b1;
        light_idx = 2'd2;
        light_x = -16'sd7000; light_y = 16'sd8000; light_z = 16'sd12;
        step();
        light_we = 1'b0;
        cmp_result(2);
        mx[2] = -7000; my[2] = 8000; mz[2] = 12;
        step();
        cmp_result(3);
        step();
        run_point(5, 6, 7, 0);
        check("new_l2_x", got_x[2], -7005);

        // Reset in the middle of a sequence
        dir_ready = 1'b1;
        accept(1, 2, 3);
        step();
        step();
        step();
        check("pre_rst_idx", dir_idx, 2);
        reset = 1'b0;
        #1;
        check("midrst_valid", dir_valid, 0);
        check("midrst_surf_ready", surf_ready, 1);
        check("midrst_x", dir_x, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        clear_model();
        run_point(-300, 400, -32768, 0);
        check("cleared_x", got_x[0], 300);
        check("cleared_y", got_y[0], -400);
        check("cleared_z_clamp", got_z[0], 32767);

        // Randomized table contents, surface points and backpressure
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                wr($urandom_range(0, NL-1), $urandom_range(0, 65535) - 32768,
                   $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
            run_point($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                      $urandom_range(0, 65535) - 32768, (it % 3 == 0) ? 0 : 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
